bank_req_fifo: RTL
==================

Name: bank_req_fifo

Overview:
Parametrised, first-word-fall-through request FIFO that buffers PE memory requests tagged with a target bank. It presents the head entry as a one-hot request to the shared-memory bank arbiters and pops only when the matching bank grants. Over a plain request FIFO it adds generic bank count and data width, almost-full, flush, starvation monitoring and sticky error flags.

Parameters:
DATA_WIDTH, 32, payload width per entry
BANK_NUM, 16, number of memory banks (one req/gnt bit each), 2..2**BANK_BITS
BANK_BITS, 4, width of bank tag; 2**BANK_BITS >= BANK_NUM
DEPTH, 16, entries; power of two, >= 2
PTR_W, 4, log2(DEPTH)
AFULL_TH, 12, almost_full threshold, 1..DEPTH
STARVE_W, 8, width of starvation counter
STARVE_LIM, 255, wait cycles that raise starve, 1..2**STARVE_W-1

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset; synchronous, active-low
flush  in  1  synchronous discard of all entries and flags
wr_en  in  1  write request
wr_bank  in  BANK_BITS  target bank of write
wr_data  in  DATA_WIDTH  payload of write
rd_en  in  1  PE allows head to request
gnt  in  BANK_NUM  per-bank grant from arbiters
req  out  BANK_NUM  one-hot request for head entry
head_data  out  DATA_WIDTH  head payload (0 when empty)
head_bank  out  BANK_BITS  head bank tag (0 when empty)
pop  out  1  head consumed this cycle
full / almost_full / empty  out  1 each  status
count  out  PTR_W+1  occupied entries, 0..DEPTH
starve_cnt  out  STARVE_W  cycles head has waited ungranted
starve  out  1  starve_cnt == STARVE_LIM
ovf_err / bank_err / gnt_err  out  1 each  sticky error flags

Behaviour:
- Reset (rst_n=0 at edge): wr_ptr, rd_ptr, count, starve_cnt = 0; all error flags 0; hence empty=1, full=0, almost_full=0, req=0, pop=0, head_* = 0. Storage array not reset. Reset wins over flush and all traffic.
- Status combinational from registered count: empty=(count==0), full=(count==DEPTH), almost_full=(count>=AFULL_TH).
- Push = wr_en & ~full & ~flush & (wr_bank < BANK_NUM). Stores {wr_bank,wr_data} at wr_ptr; wr_ptr wraps DEPTH-1 -> 0.
- wr_en & full & ~flush: write dropped, ovf_err set. Full is judged on registered count: a same-cycle pop does NOT free space for that cycle's write.
- wr_en & wr_bank >= BANK_NUM & ~flush: write dropped, bank_err set.
- Head is FWFT: head_data/head_bank = entry at rd_ptr when !empty, combinational; entry written into an empty FIFO visible the cycle after the write (no bypass).
- req = (rd_en & ~empty & ~flush) ? (1 << head_bank) : 0, combinational.
- pop = |(req & gnt). On pop rd_ptr advances (wraps) at next edge; next head appears next cycle.
- gnt & ~req nonzero: gnt_err set; those bits ignored.
- count next = count + push - pop; simultaneous push and pop leaves count unchanged.
- starve_cnt: if req!=0 & !pop -> increment, saturating at STARVE_LIM; else -> 0. starve combinational from starve_cnt.
- flush=1: next edge pointers, count, starve_cnt and all error flags -> 0; that cycle req=0, pop=0, no push, no error set.
- Error flags clear only by reset or flush.
- Latencies: write->head 1 cycle; grant->pop 0 cycles; pop->next head 1 cycle.

Test Plan:
- Reset mid-traffic: 5 entries queued, req active, rst_n=0 one cycle -> next cycle empty=1, count=0, req=0, starve_cnt=0, all errors 0.
- Order/grant: write (bank5,0xA),(bank2,0xB),(bank15,0xC), rd_en=1, gnt=0 -> req=0x0020 cycle after first write; gnt=0x0020 -> pop=1, next cycle req=0x0004, head_data=0xB, count=2.
- Full/overflow: 16 writes, no grants -> almost_full at count=12, full at 16; 17th write dropped, ovf_err=1, count=16; write+pop while full -> write dropped, count=15.
- Wrap: 40 interleaved pushes/pops, random banks -> pop order equals write order, count never exceeds 16, pointers wrap with no data loss.
- Starvation: one entry bank3, rd_en=1, gnt=0 for 300 cycles -> starve_cnt=255 and starve=1 from 255th waiting cycle, holding; gnt=0x0008 -> pop=1, starve_cnt=0 next cycle.
- Errors/flush (BANK_NUM=12): write wr_bank=13 -> dropped, bank_err=1; gnt=0x0001 while req=0x0008 -> gnt_err=1, pop=0; flush -> next cycle empty=1, all errors 0.

Source files
------------

// File: rtl/bank_req_fifo.sv
// bank_req_fifo
// First-word-fall-through request FIFO for PE memory requests. Each entry
// carries a payload plus the bank it targets. The head entry is presented to
// the bank arbiters as a one-hot request and leaves the FIFO only when the
// matching bank grants it.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   flush        synchronous discard of all entries and error flags
//   wr_en        write request
//   wr_bank      target bank of the write
//   wr_data      payload of the write
//   rd_en        PE allows the head entry to request
//   gnt          per-bank grant from the arbiters
//   req          one-hot request for the head entry
//   head_data    head payload (0 when empty)
//   head_bank    head bank tag (0 when empty)
//   pop          head consumed this cycle
//   full, almost_full, empty   occupancy status
//   count        occupied entries, 0..DEPTH
//   starve_cnt   cycles the head has waited without a grant
//   starve       starve_cnt has reached STARVE_LIM
//   ovf_err      sticky: a write arrived while full
//   bank_err     sticky: a write named a bank that does not exist
//   gnt_err      sticky: a grant arrived on a bank that was not requested
module bank_req_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int BANK_NUM   = 16,
  parameter int BANK_BITS  = 4,
  parameter int DEPTH      = 16,
  parameter int PTR_W      = 4,
  parameter int AFULL_TH   = 12,
  parameter int STARVE_W   = 8,
  parameter int STARVE_LIM = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [BANK_BITS-1:0]  wr_bank,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [BANK_NUM-1:0]   gnt,
  output logic [BANK_NUM-1:0]   req,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [BANK_BITS-1:0]  head_bank,
  output logic                  pop,
  output logic                  full,
  output logic                  almost_full,
  output logic                  empty,
  output logic [PTR_W:0]        count,
  output logic [STARVE_W-1:0]   starve_cnt,
  output logic                  starve,
  output logic                  ovf_err,
  output logic                  bank_err,
  output logic                  gnt_err
);

  localparam int EntryW = BANK_BITS + DATA_WIDTH;

  // Sized copies of the thresholds so every comparison is width-matched.
  // The bank limit needs one extra bit because BANK_NUM may equal 2**BANK_BITS.
  localparam logic [PTR_W:0]       DepthC     = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]       AfullC     = (PTR_W+1)'(AFULL_TH);
  localparam logic [BANK_BITS:0]   BankNumC   = (BANK_BITS+1)'(BANK_NUM);
  localparam logic [STARVE_W-1:0]  StarveLimC = STARVE_W'(STARVE_LIM);

  logic [EntryW-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
  logic [PTR_W:0]      count_q, count_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                ovf_q, ovf_d;
  logic                bankErr_q, bankErr_d;
  logic                gntErr_q, gntErr_d;

  logic                bankOk;
  logic                push;
  logic                reqActive;
  logic [EntryW-1:0]   headEntry;

  // Status is derived from the registered count only, so a pop in the same
  // cycle never makes room for a write that arrives while full.
  assign empty       = (count_q == '0);
  assign full        = (count_q == DepthC);
  assign almost_full = (count_q >= AfullC);
  assign count       = count_q;

  assign bankOk = ({1'b0, wr_bank} < BankNumC);
  assign push   = wr_en & ~full & ~flush & bankOk;

  // Fall-through head: no bypass, so a write into an empty FIFO shows up
  // one cycle later once count has been updated.
  assign headEntry = mem_q[rdPtr_q];
  assign head_data = empty ? '0 : headEntry[DATA_WIDTH-1:0];
  assign head_bank = empty ? '0 : headEntry[EntryW-1:DATA_WIDTH];

  assign reqActive = rd_en & ~empty & ~flush;

  // One-hot decode of the head bank towards the arbiters.
  always_comb begin
    req = '0;
    for (int i = 0; i < BANK_NUM; i++) begin
      req[i] = reqActive && (head_bank == BANK_BITS'(i));
    end
  end

  // A grant only counts on the requested bank; stray grant bits are
  // ignored here and flagged through gnt_err.
  assign pop = |(req & gnt);

  assign starve_cnt = starve_q;
  assign starve     = (starve_q == StarveLimC);
  assign ovf_err    = ovf_q;
  assign bank_err   = bankErr_q;
  assign gnt_err    = gntErr_q;

  // Next-state for pointers, occupancy, starvation counter and error flags.
  // Flush returns everything to the empty, error-free state.
  always_comb begin
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    count_d   = count_q;
    starve_d  = '0;
    ovf_d     = ovf_q;
    bankErr_d = bankErr_q;
    gntErr_d  = gntErr_q;

    if (flush) begin
      wrPtr_d   = '0;
      rdPtr_d   = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
      bankErr_d = 1'b0;
      gntErr_d  = 1'b0;
    end else begin
      if (push) begin
        wrPtr_d = wrPtr_q + PTR_W'(1);
      end
      if (pop) begin
        rdPtr_d = rdPtr_q + PTR_W'(1);
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase

      // Waiting head counts up and saturates; any pop or idle cycle resets it.
      if ((|req) && !pop) begin
        starve_d = (starve_q == StarveLimC) ? starve_q : starve_q + STARVE_W'(1);
      end

      ovf_d     = ovf_q     | (wr_en & full);
      bankErr_d = bankErr_q | (wr_en & ~bankOk);
      gntErr_d  = gntErr_q  | (|(gnt & ~req));
    end
  end

  // Control state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      starve_q  <= '0;
      ovf_q     <= 1'b0;
      bankErr_q <= 1'b0;
      gntErr_q  <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      starve_q  <= starve_d;
      ovf_q     <= ovf_d;
      bankErr_q <= bankErr_d;
      gntErr_q  <= gntErr_d;
    end
  end

  // Storage is not reset; entries are only meaningful below count.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[wrPtr_q] <= {wr_bank, wr_data};
    end
  end

endmodule
